// File: rtl/cacheline_burst_adapter_if.sv
// Cache-side request/response and burst-memory signal bundle
// of the cache line burst adapter.
interface cacheline_burst_adapter_if #(
  parameter int LINE_WIDTH = 256,
  parameter int BUS_WIDTH  = 64,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_read;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LINE_WIDTH-1:0] req_wdata;
  logic                  req_ready;
  logic [LINE_WIDTH-1:0] resp_rdata;
  logic                  resp_valid;
  logic                  write_done;
  logic [ADDR_WIDTH-1:0] bmem_addr;
  logic                  bmem_read;
  logic                  bmem_write;
  logic [BUS_WIDTH-1:0]  bmem_wdata;
  logic                  bmem_ready;
  logic [BUS_WIDTH-1:0]  bmem_rdata;
  logic                  bmem_rvalid;

  modport master (
    input  req_read,
    input  req_write,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output resp_rdata,
    output resp_valid,
    output write_done,
    output bmem_addr,
    output bmem_read,
    output bmem_write,
    output bmem_wdata,
    input  bmem_ready,
    input  bmem_rdata,
    input  bmem_rvalid
  );

  modport slave (
    output req_read,
    output req_write,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  resp_rdata,
    input  resp_valid,
    input  write_done,
    input  bmem_addr,
    input  bmem_read,
    input  bmem_write,
    input  bmem_wdata,
    output bmem_ready,
    output bmem_rdata,
    output bmem_rvalid
  );
endinterface

// File: rtl/cacheline_burst_adapter.sv
// Gathers memory read beats into cache lines and serialises
// dirty lines into memory write beats.
module cacheline_burst_adapter #(
  parameter int LINE_WIDTH = 256,
  parameter int BUS_WIDTH  = 64,
  parameter int ADDR_WIDTH = 32
) (
  input logic clk,
  input logic rst,
  cacheline_burst_adapter_if.master bus
);
  localparam int BEATS = LINE_WIDTH / BUS_WIDTH;
  localparam int CW    = $clog2(BEATS);
  localparam int OFF   = $clog2(LINE_WIDTH / 8);

  if ((LINE_WIDTH % BUS_WIDTH) != 0 || BEATS < 2) begin : g_bad_cfg
    $error("LINE_WIDTH must be >= 2 whole BUS_WIDTH beats");
  end

  typedef enum logic [1:0] {
    IDLE,
    RD_CMD,
    RD_COLLECT,
    WR_BURST
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [CW-1:0]         beat_q;
  logic [LINE_WIDTH-1:0] line_q;
  logic [LINE_WIDTH-1:0] rdata_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  resp_valid_q;
  logic                  write_done_q;
  logic                  last;
  logic                  accept;
  logic                  rd_beat;
  logic                  wr_beat;
  logic                  unused_addr;

  assign last    = beat_q == CW'(BEATS - 1);
  assign accept  = (state_q == IDLE)
                 && (bus.req_read || bus.req_write);
  assign rd_beat = (state_q == RD_COLLECT) && bus.bmem_rvalid;
  assign wr_beat = (state_q == WR_BURST) && bus.bmem_ready;
  assign unused_addr = ^bus.req_addr[OFF-1:0];

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_write)     state_d = WR_BURST;
        else if (bus.req_read) state_d = RD_CMD;
      end
      RD_CMD:     if (bus.bmem_ready) state_d = RD_COLLECT;
      RD_COLLECT: if (rd_beat && last) state_d = IDLE;
      WR_BURST:   if (wr_beat && last) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q       <= '0;
      line_q       <= '0;
      rdata_q      <= '0;
      addr_q       <= '0;
      resp_valid_q <= 1'b0;
      write_done_q <= 1'b0;
    end else begin
      resp_valid_q <= rd_beat && last;
      write_done_q <= wr_beat && last;
      if (accept) begin
        addr_q <= {bus.req_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
        line_q <= bus.req_wdata;
        beat_q <= '0;
      end
      if (rd_beat) begin
        line_q[beat_q*BUS_WIDTH +: BUS_WIDTH] <= bus.bmem_rdata;
        beat_q <= beat_q + CW'(1);
        // only a complete line ever reaches the response register
        if (last) begin
          rdata_q <= {bus.bmem_rdata,
                      line_q[LINE_WIDTH-BUS_WIDTH-1:0]};
        end
      end
      if (wr_beat) beat_q <= beat_q + CW'(1);
    end
  end

  assign bus.req_ready  = state_q == IDLE;
  assign bus.bmem_read  = state_q == RD_CMD;
  assign bus.bmem_write = state_q == WR_BURST;
  assign bus.bmem_addr  = addr_q;
  assign bus.bmem_wdata = (state_q == WR_BURST)
                        ? line_q[beat_q*BUS_WIDTH +: BUS_WIDTH]
                        : '0;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.write_done = write_done_q;
endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Randomised scoreboard bench for the cache line burst adapter,
// covering a 4-beat and an 8-beat configuration.
module tb_cacheline_burst_adapter;
  localparam int BW  = 64;
  localparam int AW  = 32;
  localparam int LWA = 256;
  localparam int NBA = LWA / BW;
  localparam int LWB = 512;
  localparam int NBB = LWB / BW;

  typedef logic [511:0]   wide_t;
  typedef logic [BW-1:0]  beat_t;
  typedef struct { wide_t line; int cyc; } resp_t;
  typedef struct { beat_t data; logic [AW-1:0] addr; } wbeat_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   n_resp_a = 0;
  int   n_resp_b = 0;
  wide_t last_a = '0;
  wide_t last_b = '0;

  resp_t         rq_a[$];
  resp_t         rq_b[$];
  wbeat_t        wq_a[$];
  int            dq_a[$];
  logic [AW-1:0] aq_a[$];
  logic [AW-1:0] aq_b[$];

  beat_t dir_rd[NBA] = '{64'hCAFEBABE14159265,
                         64'hDEADBEEF12345678,
                         64'hFECEBECE87654321,
                         64'hABCDABCD12341234};
  beat_t dir_wr[NBA] = '{64'h0000000000000000,
                         64'h1111111111111111,
                         64'h2222222222222222,
                         64'h3333333333333333};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cacheline_burst_adapter_if #(
    .LINE_WIDTH(LWA), .BUS_WIDTH(BW), .ADDR_WIDTH(AW)
  ) ba ();
  cacheline_burst_adapter_if #(
    .LINE_WIDTH(LWB), .BUS_WIDTH(BW), .ADDR_WIDTH(AW)
  ) bb ();

  cacheline_burst_adapter #(
    .LINE_WIDTH(LWA), .BUS_WIDTH(BW), .ADDR_WIDTH(AW)
  ) dut_a (.clk(clk), .rst(rst), .bus(ba));
  cacheline_burst_adapter #(
    .LINE_WIDTH(LWB), .BUS_WIDTH(BW), .ADDR_WIDTH(AW)
  ) dut_b (.clk(clk), .rst(rst), .bus(bb));

  task automatic chk(input string name, input wide_t act,
                     input wide_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic wide_t rnd_wide();
    wide_t r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // spec rule: beat k of a line is bits [k*BW +: BW]
  function automatic beat_t beat_of(input wide_t line, input int k);
    return beat_t'(line >> (k * BW));
  endfunction

  task automatic mon_a();
    resp_t  e;
    wbeat_t w;
    if (ba.resp_valid) begin
      n_resp_a++;
      chk("a_resp_expected", rq_a.size() > 0, 1'b1);
      if (rq_a.size() > 0) begin
        e = rq_a.pop_front();
        chk("a_resp_line", ba.resp_rdata, e.line);
        chk("a_resp_cycle", cyc, e.cyc);
      end
    end
    if (ba.bmem_read && ba.bmem_ready) begin
      chk("a_rd_cmd_expected", aq_a.size() > 0, 1'b1);
      if (aq_a.size() > 0)
        chk("a_rd_addr", ba.bmem_addr, aq_a.pop_front());
    end
    if (ba.bmem_write) begin
      chk("a_wr_expected", wq_a.size() > 0, 1'b1);
      if (wq_a.size() > 0) begin
        w = wq_a[0];
        chk("a_wr_data", ba.bmem_wdata, w.data);
        chk("a_wr_addr", ba.bmem_addr, w.addr);
        if (ba.bmem_ready) void'(wq_a.pop_front());
      end
    end
    if (ba.write_done) begin
      chk("a_done_expected", dq_a.size() > 0, 1'b1);
      if (dq_a.size() > 0)
        chk("a_done_cycle", cyc, dq_a.pop_front());
    end
  endtask

  task automatic mon_b();
    resp_t e;
    if (bb.resp_valid) begin
      n_resp_b++;
      chk("b_resp_expected", rq_b.size() > 0, 1'b1);
      if (rq_b.size() > 0) begin
        e = rq_b.pop_front();
        chk("b_resp_line", bb.resp_rdata, e.line);
        chk("b_resp_cycle", cyc, e.cyc);
      end
    end
    if (bb.bmem_read && bb.bmem_ready) begin
      chk("b_rd_cmd_expected", aq_b.size() > 0, 1'b1);
      if (aq_b.size() > 0)
        chk("b_rd_addr", bb.bmem_addr, aq_b.pop_front());
    end
    if (bb.bmem_write) chk("b_no_write", bb.bmem_write, 1'b0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon_a();
      mon_b();
    end
  end

  task automatic wait_ready_a();
    int n = 0;
    while (!ba.req_ready && n < 50) begin
      tick();
      n++;
    end
    chk("a_req_ready_wait", ba.req_ready, 1'b1);
  endtask

  task automatic wait_ready_b();
    int n = 0;
    while (!bb.req_ready && n < 50) begin
      tick();
      n++;
    end
    chk("b_req_ready_wait", bb.req_ready, 1'b1);
  endtask

  // mode 0: memory always ready, no gaps; 1: gap pattern 1,0,1,0,1,1
  // 2: random command back-pressure and random gaps
  task automatic read_a(input logic [AW-1:0] addr,
                        input beat_t beats[NBA],
                        input wide_t exp, input int mode);
    int n = 0;
    int gaps;
    int gp[4] = '{0, 1, 1, 0};
    wait_ready_a();
    ba.req_read = 1'b1;
    ba.req_addr = addr;
    aq_a.push_back(addr & ~32'(LWA / 8 - 1));
    tick();
    ba.req_read = 1'b0;
    ba.req_addr = $urandom;
    if (mode == 0) begin
      chk("a_rd_cmd_cycle1", ba.bmem_read, 1'b1);
      chk("a_busy_cycle1", ba.req_ready, 1'b0);
    end
    ba.bmem_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    while (!(ba.bmem_read && ba.bmem_ready) && n < 50) begin
      tick();
      ba.bmem_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      n++;
    end
    chk("a_rd_cmd_accepted", ba.bmem_read && ba.bmem_ready, 1'b1);
    tick();
    ba.bmem_ready = 1'($urandom_range(0, 1));
    for (int k = 0; k < NBA; k++) begin
      gaps = (mode == 1) ? gp[k] :
             (mode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (gaps) begin
        ba.bmem_rvalid = 1'b0;
        ba.bmem_rdata  = {$urandom, $urandom};
        tick();
      end
      ba.bmem_rvalid = 1'b1;
      ba.bmem_rdata  = beats[k];
      if (k == NBA - 1) begin
        rq_a.push_back('{line: exp, cyc: cyc + 1});
        last_a = exp;
      end
      tick();
    end
    ba.bmem_rvalid = 1'b0;
    ba.bmem_ready  = 1'b0;
  endtask

  // mode 0: always ready; 1: ready pattern 1,0,0,1,1,0,1; 2: random
  task automatic write_a(input logic [AW-1:0] addr, input wide_t line,
                         input beat_t beats[NBA], input int mode,
                         input bit with_read);
    int acc = 0;
    int n = 0;
    bit pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    wait_ready_a();
    ba.req_write = 1'b1;
    ba.req_read  = with_read;
    ba.req_addr  = addr;
    ba.req_wdata = line[LWA-1:0];
    for (int k = 0; k < NBA; k++)
      wq_a.push_back('{data: beats[k],
                       addr: addr & ~32'(LWA / 8 - 1)});
    tick();
    ba.req_write = 1'b0;
    ba.req_read  = 1'b0;
    ba.req_wdata = rnd_wide();
    if (mode == 0) chk("a_wr_beat0_cycle1", ba.bmem_write, 1'b1);
    while (acc < NBA && n < 100) begin
      ba.bmem_ready = (mode == 0) ? 1'b1 :
                      (mode == 1) ? pat[n % 7] :
                      1'($urandom_range(0, 1));
      if (ba.bmem_write && ba.bmem_ready) begin
        acc++;
        if (acc == NBA) dq_a.push_back(cyc + 1);
      end
      tick();
      n++;
    end
    ba.bmem_ready = 1'b0;
    chk("a_wr_accepts", acc, NBA);
  endtask

  task automatic rand_read_a(input int mode);
    wide_t l = rnd_wide();
    beat_t b[NBA];
    for (int k = 0; k < NBA; k++) b[k] = beat_of(l, k);
    read_a($urandom, b, wide_t'(l[LWA-1:0]), mode);
  endtask

  task automatic rand_write_a(input int mode, input bit with_read);
    wide_t l = rnd_wide();
    beat_t b[NBA];
    for (int k = 0; k < NBA; k++) b[k] = beat_of(l, k);
    write_a($urandom, l, b, mode, with_read);
  endtask

  task automatic read_b(input logic [AW-1:0] addr, input int mode);
    wide_t l = rnd_wide();
    int n = 0;
    int gaps;
    wait_ready_b();
    bb.req_read = 1'b1;
    bb.req_addr = addr;
    aq_b.push_back(addr & ~32'(LWB / 8 - 1));
    tick();
    bb.req_read = 1'b0;
    bb.bmem_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    while (!(bb.bmem_read && bb.bmem_ready) && n < 50) begin
      tick();
      bb.bmem_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      n++;
    end
    chk("b_rd_cmd_accepted", bb.bmem_read && bb.bmem_ready, 1'b1);
    tick();
    bb.bmem_ready = 1'b0;
    for (int k = 0; k < NBB; k++) begin
      gaps = (mode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (gaps) begin
        bb.bmem_rvalid = 1'b0;
        bb.bmem_rdata  = {$urandom, $urandom};
        tick();
      end
      bb.bmem_rvalid = 1'b1;
      bb.bmem_rdata  = beat_of(l, k);
      if (k == NBB - 1) begin
        rq_b.push_back('{line: l, cyc: cyc + 1});
        last_b = l;
      end
      tick();
    end
    bb.bmem_rvalid = 1'b0;
  endtask

  task automatic check_reset_a();
    chk("rst_req_ready", ba.req_ready, 1'b1);
    chk("rst_resp_valid", ba.resp_valid, 1'b0);
    chk("rst_write_done", ba.write_done, 1'b0);
    chk("rst_bmem_read", ba.bmem_read, 1'b0);
    chk("rst_bmem_write", ba.bmem_write, 1'b0);
    chk("rst_bmem_addr", ba.bmem_addr, '0);
    chk("rst_bmem_wdata", ba.bmem_wdata, '0);
    chk("rst_resp_rdata", ba.resp_rdata, '0);
  endtask

  task automatic stray_a();
    repeat (3) begin
      ba.bmem_rvalid = 1'b1;
      ba.bmem_rdata  = {$urandom, $urandom};
      tick();
    end
    ba.bmem_rvalid = 1'b0;
    chk("a_stray_rdata_kept", ba.resp_rdata, last_a[LWA-1:0]);
    chk("a_stray_idle", ba.req_ready, 1'b1);
  endtask

  task automatic stray_b();
    repeat (3) begin
      bb.bmem_rvalid = 1'b1;
      bb.bmem_rdata  = {$urandom, $urandom};
      tick();
    end
    bb.bmem_rvalid = 1'b0;
    chk("b_stray_rdata_kept", bb.resp_rdata, last_b);
    chk("b_stray_idle", bb.req_ready, 1'b1);
  endtask

  task automatic abort_a();
    wait_ready_a();
    ba.req_read = 1'b1;
    ba.req_addr = $urandom;
    aq_a.push_back(ba.req_addr & ~32'(LWA / 8 - 1));
    tick();
    ba.req_read   = 1'b0;
    ba.bmem_ready = 1'b1;
    tick();
    ba.bmem_ready = 1'b0;
    repeat (2) begin
      ba.bmem_rvalid = 1'b1;
      ba.bmem_rdata  = {$urandom, $urandom};
      tick();
    end
    ba.bmem_rvalid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_a = '0;
    last_b = '0;
    check_reset_a();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    rst = 1'b1;
    ba.req_read = 1'b0;  ba.req_write = 1'b0;
    ba.req_addr = '0;    ba.req_wdata = '0;
    ba.bmem_ready = 1'b0; ba.bmem_rvalid = 1'b0;
    ba.bmem_rdata = '0;
    bb.req_read = 1'b0;  bb.req_write = 1'b0;
    bb.req_addr = '0;    bb.req_wdata = '0;
    bb.bmem_ready = 1'b0; bb.bmem_rvalid = 1'b0;
    bb.bmem_rdata = '0;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_a();
    chk("b_rst_req_ready", bb.req_ready, 1'b1);

    read_a(32'h0000_1234, dir_rd,
           256'hABCDABCD12341234_FECEBECE87654321_DEADBEEF12345678_CAFEBABE14159265,
           0);
    read_a(32'h0000_5678, dir_rd,
           256'hABCDABCD12341234_FECEBECE87654321_DEADBEEF12345678_CAFEBABE14159265,
           1);
    write_a(32'h0000_2000,
            256'h3333333333333333_2222222222222222_1111111111111111_0000000000000000,
            dir_wr, 1, 1'b0);
    rand_write_a(0, 1'b1);
    repeat (3) tick();
    chk("a_rw_no_refill", ba.req_ready, 1'b1);

    abort_a();
    rand_read_a(2);

    stray_a();
    base = n_resp_a;
    rand_read_a(0);
    rand_read_a(0);
    repeat (2) tick();
    chk("a_two_resp", n_resp_a - base, 2);

    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 1) rand_read_a(2);
      else rand_write_a(2, 1'($urandom_range(0, 1)));
    end

    stray_b();
    base = n_resp_b;
    read_b($urandom, 0);
    read_b($urandom, 0);
    repeat (2) tick();
    chk("b_two_resp", n_resp_b - base, 2);
    for (int i = 0; i < 4; i++) read_b($urandom, 2);

    repeat (5) tick();
    chk("a_resp_drained", rq_a.size(), 0);
    chk("a_wr_drained", wq_a.size(), 0);
    chk("a_done_drained", dq_a.size(), 0);
    chk("a_cmd_drained", aq_a.size(), 0);
    chk("b_resp_drained", rq_b.size(), 0);
    chk("b_cmd_drained", aq_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cacheline_burst_adapter.md
# cacheline_burst_adapter

Parametrised bidirectional adapter between the cache and the burst memory interface. It gathers BEATS consecutive memory read beats into one cache line, and it serialises a dirty line into BEATS write beats. Read-data gaps (bmem_rvalid dropping mid-burst) and memory back-pressure are both tolerated. It sits between the cache miss/writeback logic and the bmem port.

## Interface
- LINE_WIDTH, 256, cache line width in bits
- BUS_WIDTH, 64, memory beat width in bits; LINE_WIDTH must be a multiple of BUS_WIDTH, and BEATS = LINE_WIDTH/BUS_WIDTH must be ≥ 2 (elaboration error otherwise)
- ADDR_WIDTH, 32, byte address width

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- req_read  in  1  line refill request
- req_write  in  1  line writeback request
- req_addr  in  ADDR_WIDTH  line address; low log2(LINE_WIDTH/8) bits ignored
- req_wdata  in  LINE_WIDTH  writeback line
- req_ready  out  1  adapter idle, request accepted this cycle if req_read|req_write
- resp_rdata  out  LINE_WIDTH  assembled line, valid with resp_valid
- resp_valid  out  1  one-cycle pulse, refill complete
- write_done  out  1  one-cycle pulse, writeback complete
- bmem_addr  out  ADDR_WIDTH  line-aligned address (low bits forced 0)
- bmem_read  out  1  read command
- bmem_write  out  1  write beat valid
- bmem_wdata  out  BUS_WIDTH  current write beat
- bmem_ready  in  1  memory accepts command/beat this cycle
- bmem_rdata  in  BUS_WIDTH  read beat
- bmem_rvalid  in  1  read beat valid

## Operation
- States: IDLE, RD_CMD, RD_COLLECT, WR_BURST. Beat counter is $clog2(BEATS) bits wide.
- IDLE: req_ready=1.
  - req_write takes priority over a simultaneous req_read. Writeback precedes refill, and the read is not latched.
  - On accept, latch the aligned address and req_wdata, clear the counter, then go to WR_BURST or RD_CMD.
- RD_CMD: bmem_read=1 with bmem_addr held. Leave for RD_COLLECT on the cycle bmem_ready=1, so the command lasts exactly one accepted cycle.
- RD_COLLECT:
  - On each bmem_rvalid, write bmem_rdata into bits [k*BUS_WIDTH +: BUS_WIDTH] and increment k.
  - Cycles with bmem_rvalid=0 change nothing.
  - After beat BEATS-1 is captured, go to IDLE and pulse resp_valid.
- WR_BURST:
  - bmem_write=1, bmem_addr held, bmem_wdata = latched line beat k (beat 0 = bits [BUS_WIDTH-1:0]).
  - k advances only when bmem_ready=1; otherwise the beat is held.
  - After beat BEATS-1 is accepted, go to IDLE and pulse write_done.
- bmem_rvalid outside RD_COLLECT is ignored, with no state or data change.
- resp_rdata holds the last completed line until the next refill completes. Partially filled lines are never exposed through resp_valid.
- Reset, including mid-burst:
  - state IDLE, counter 0, partial line discarded.
  - req_ready=1; resp_valid=0, write_done=0, bmem_read=0, bmem_write=0.
  - bmem_addr=0, bmem_wdata=0, resp_rdata=0.

## Timing
- Request accepted in cycle 0.
- Read:
  - bmem_read=1 from cycle 1.
  - If the last beat is captured in cycle N, resp_valid=1 in cycle N+1 only, and req_ready=1 from cycle N+1.
  - Back-to-back refill: with bmem_ready=1 throughout, the earliest 4-beat case gives bmem_read in cycle 1, beats in cycles 2–5, resp_valid in cycle 6.
- Write:
  - Beat 0 is presented in cycle 1.
  - If bmem_ready=1 throughout, beats are accepted in cycles 1..BEATS and write_done=1 in cycle BEATS+1.
- A new request may be accepted in the same cycle resp_valid or write_done is high.
- All outputs are registered or decoded from registered state only; no input→output combinational path.

## Test plan
- Reset then refill at req_addr=0x0000_1234:
  - bmem_addr=0x0000_1220 (line-aligned).
  - Beats CAFEBABE14159265, DEADBEEF12345678, FECEBECE87654321, ABCDABCD12341234 arrive back-to-back.
  - resp_rdata = ABCDABCD12341234_FECEBECE87654321_DEADBEEF12345678_CAFEBABE14159265.
  - One resp_valid pulse, one cycle after the 4th beat.
- Same beats with bmem_rvalid=0 gaps (pattern 1,0,1,0,1,1; rdata=X in gaps) -> identical line; resp_valid one cycle after the final beat; no early pulse.
- Writeback of line 0x…_3333_2222_1111_0000 (beats 0x0,0x1111,0x2222,0x3333 × replicated):
  - bmem_ready toggles 1,0,0,1,1,0,1.
  - Each beat is held while ready=0, in order 0..3.
  - write_done pulses once, one cycle after the 4th acceptance.
- Simultaneous req_read & req_write -> write burst only; no bmem_read issued.
- rst asserted after 2 read beats, then new refill -> no resp_valid for the aborted line; new line is correct with no stale beats.
- Stray bmem_rvalid in IDLE, then two back-to-back refills (4 beats each) -> lines are correct and exactly two resp_valid pulses; also rerun with LINE_WIDTH=512, BUS_WIDTH=64 (8 beats).
